// File: rtl/qdrii_resp_pkg.sv
// qdrii_resp_pkg: shared constants and helpers for the QDRII burst-of-2 SRAM
// responder.
//   BURST_LEN   beats per read or write burst
//   RD_LAT_MIN  smallest command-to-first-beat read latency the pipeline supports
//   RD_LAT_MAX  largest command-to-first-beat read latency the pipeline supports
//   beat_idx_t  index of a beat within a burst
//   lane_width  width of one byte lane
package qdrii_resp_pkg;

  localparam int BURST_LEN  = 2;
  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 8;

  typedef logic [$clog2(BURST_LEN)-1:0] beat_idx_t;

  function automatic int lane_width(input int data_width, input int bw_width);
    return data_width / bw_width;
  endfunction

endpackage

// File: rtl/qdrii_resp_bytemem.sv
// qdrii_resp_bytemem: one-write / one-read synchronous RAM with per-lane
// write enables. A read and a write to the same word on the same edge
// return the old word (read-before-write).
//   clk      clock
//   rst_n    asynchronous active-low reset, clears only the read data register
//   we       write enable
//   lane_we  per-lane write enable, active-high
//   waddr    write word address
//   wdata    write data
//   re       read enable
//   raddr    read word address
//   rdata    registered read data; holds its value while re is low
module qdrii_resp_bytemem
  import qdrii_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [BW_WIDTH-1:0]   lane_we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int LW = lane_width(DATA_WIDTH, BW_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < BW_WIDTH; l++) begin
      if (we && lane_we[l]) begin
        mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
      end
    end
  end

  // Non-blocking read of the array gives the pre-write word on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/qdrii_sram_resp.sv
// qdrii_sram_resp: memory-side QDRII burst-of-2 SRAM responder, one beat per
// sys_clk.
//   sys_clk    sole clock
//   sys_rst    asynchronous reset, active-low
//   dll_off_n  low = DLL off: commands ignored, lock counter held at 0
//   r_n, w_n   read / write command strobes, active-low
//   sa         burst address, sampled with the command
//   d, bw_n    write data beat and per-lane active-low write enables
//   q, q_valid read data beat and its qualifier; q holds while q_valid is low
//   ready      DLL lock complete, commands accepted
//   proto_err  sticky: a command arrived while that port's burst was busy
//
// Command handshake: a command is taken at the edge closing cycle t when its
// strobe is low, ready is high, dll_off_n is high and its port is not busy
// (busy = the cycle right after that port accepted a command). There is no
// other flow control; a refused command is simply dropped.
// RD_LAT must lie in RD_LAT_MIN..RD_LAT_MAX.
module qdrii_sram_resp
  import qdrii_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 36,
  parameter int BW_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 18,
  parameter int MEM_AW      = 10,
  parameter int RD_LAT      = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  dll_off_n,
  input  logic                  r_n,
  input  logic                  w_n,
  input  logic [ADDR_WIDTH-1:0] sa,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [BW_WIDTH-1:0]   bw_n,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  ready,
  output logic                  proto_err
);

  localparam int CW    = $clog2(LOCK_CYCLES + 1);
  localparam int EXTRA = RD_LAT - RD_LAT_MIN;

  // ---------------- DLL lock ----------------
  logic [CW-1:0] lock_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lock_cnt <= '0;
    end else if (!dll_off_n) begin
      lock_cnt <= '0;
    end else if (lock_cnt != CW'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign ready = (lock_cnt == CW'(LOCK_CYCLES));

  // ---------------- command acceptance ----------------
  logic cmd_en, rd_req, wr_req, rd_acc, wr_acc;
  // ph0: beat 0 in progress (port busy); ph1: beat 1 in progress.
  logic rd_ph0, rd_ph1, wr_ph0, wr_ph1;
  logic [MEM_AW-2:0] rd_base, wr_base;
  beat_idx_t rd_beat, wr_beat;

  assign cmd_en = ready & dll_off_n;
  assign rd_req = cmd_en & ~r_n;
  assign wr_req = cmd_en & ~w_n;
  assign rd_acc = rd_req & ~rd_ph0;
  assign wr_acc = wr_req & ~wr_ph0;
  assign rd_beat = rd_ph1;
  assign wr_beat = wr_ph1;

  // Upper sa bits alias onto the array.
  logic unused_sa;
  assign unused_sa = ^sa[ADDR_WIDTH-1:MEM_AW-1];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_ph0    <= 1'b0;
      rd_ph1    <= 1'b0;
      wr_ph0    <= 1'b0;
      wr_ph1    <= 1'b0;
      rd_base   <= '0;
      wr_base   <= '0;
      proto_err <= 1'b0;
    end else begin
      rd_ph0 <= rd_acc;
      rd_ph1 <= rd_ph0;
      wr_ph0 <= wr_acc;
      wr_ph1 <= wr_ph0;
      if (rd_acc) rd_base <= sa[MEM_AW-2:0];
      if (wr_acc) wr_base <= sa[MEM_AW-2:0];
      proto_err <= proto_err | (rd_req & rd_ph0) | (wr_req & wr_ph0);
    end
  end

  // ---------------- array ----------------
  logic [DATA_WIDTH-1:0] samp_d;
  logic                  samp_v;

  qdrii_resp_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .BW_WIDTH   (BW_WIDTH),
    .AW         (MEM_AW)
  ) u_mem (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .we      (wr_ph0 | wr_ph1),
    .lane_we (~bw_n),
    .waddr   ({wr_base, wr_beat}),
    .wdata   (d),
    .re      (rd_ph0 | rd_ph1),
    .raddr   ({rd_base, rd_beat}),
    .rdata   (samp_d)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) samp_v <= 1'b0;
    else          samp_v <= rd_ph0 | rd_ph1;
  end

  // ---------------- read latency pipeline ----------------
  // Data stages load only with a valid beat so q holds between bursts.
  if (EXTRA > 0) begin : g_pipe
    logic [EXTRA-1:0]                 pipe_v;
    logic [EXTRA-1:0][DATA_WIDTH-1:0] pipe_d;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        pipe_v <= '0;
        pipe_d <= '0;
      end else begin
        pipe_v[0] <= samp_v;
        if (samp_v) pipe_d[0] <= samp_d;
        for (int k = 1; k < EXTRA; k++) begin
          pipe_v[k] <= pipe_v[k-1];
          if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
        end
      end
    end

    assign q       = pipe_d[EXTRA-1];
    assign q_valid = pipe_v[EXTRA-1];
  end else begin : g_nopipe
    assign q       = samp_d;
    assign q_valid = samp_v;
  end

endmodule

// File: tb/tb_qdrii_sram_resp.sv
// tb_qdrii_sram_resp: bench for qdrii_sram_resp with a cycle-level model of
// the responder rules and directed scenarios with literal expectations.
module tb_qdrii_sram_resp;

  localparam int DW     = 36;
  localparam int BW     = 4;
  localparam int AW     = 18;
  localparam int MAW    = 10;
  localparam int RD_LAT = 3;
  localparam int LOCK   = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          sys_rst, dll_off_n, r_n, w_n;
  logic [AW-1:0] sa;
  logic [DW-1:0] d;
  logic [BW-1:0] bw_n;
  logic [DW-1:0] q;
  logic          q_valid, ready, proto_err;

  always #5 clk = ~clk;

  qdrii_sram_resp #(
    .DATA_WIDTH (DW),
    .BW_WIDTH   (BW),
    .ADDR_WIDTH (AW),
    .MEM_AW     (MAW),
    .RD_LAT     (RD_LAT),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (sys_rst),
    .dll_off_n(dll_off_n),
    .r_n      (r_n),
    .w_n      (w_n),
    .sa       (sa),
    .d        (d),
    .bw_n     (bw_n),
    .q        (q),
    .q_valid  (q_valid),
    .ready    (ready),
    .proto_err(proto_err)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in cycles; cycle c is the period after the c-th posedge.
  int            cyc = 0;
  logic [DW-1:0] mmem [int];        // word address -> contents
  int            rd_addr [int];     // cycle whose closing edge samples -> word
  int            rd_out  [int];     // same key -> cycle the beat appears
  int            wr_addr [int];     // cycle whose closing edge commits -> word
  bit            exp_at  [int];     // cycles in which q_valid must be 1
  logic [DW-1:0] exp_q [$];         // expected read beats, in order
  int            last_rd, last_wr, lock_m;
  bit            m_ready, m_perr;
  logic [DW-1:0] m_q;

  always @(posedge clk) begin
    int t, a;
    logic [DW-1:0] w;
    t = cyc;
    if (!sys_rst) begin
      rd_addr.delete(); rd_out.delete(); wr_addr.delete(); exp_at.delete();
      exp_q.delete();
      last_rd = -10; last_wr = -10; lock_m = 0;
      m_ready = 0; m_perr = 0; m_q = '0;
    end else begin
      // Reads see the array before this edge's write commit.
      if (rd_addr.exists(t)) begin
        a = rd_addr[t];
        exp_q.push_back(mmem.exists(a) ? mmem[a] : {DW{1'bx}});
        exp_at[rd_out[t]] = 1;
      end
      if (wr_addr.exists(t)) begin
        a = wr_addr[t];
        w = mmem.exists(a) ? mmem[a] : {DW{1'bx}};
        for (int l = 0; l < BW; l++)
          if (!bw_n[l]) w[l*9 +: 9] = d[l*9 +: 9];
        mmem[a] = w;
      end
      if (m_ready && dll_off_n) begin
        a = (int'(sa) % 512) * 2;
        if (!r_n) begin
          if (last_rd == t - 1) m_perr = 1;
          else begin
            last_rd = t;
            rd_addr[t+1] = a;     rd_out[t+1] = t + RD_LAT;
            rd_addr[t+2] = a + 1; rd_out[t+2] = t + RD_LAT + 1;
          end
        end
        if (!w_n) begin
          if (last_wr == t - 1) m_perr = 1;
          else begin
            last_wr = t;
            wr_addr[t+1] = a;
            wr_addr[t+2] = a + 1;
          end
        end
      end
      if (!dll_off_n) lock_m = 0;
      else if (lock_m < LOCK) lock_m++;
      m_ready = (lock_m == LOCK);
    end
    cyc = t + 1;
  end

  // Compare every cycle, 2 time units after the active edge.
  always @(posedge clk) begin
    bit ev;
    #2;
    ev = exp_at.exists(cyc);
    if (ev && exp_q.size() > 0) m_q = exp_q.pop_front();
    chk("q_valid", {35'd0, q_valid}, {35'd0, ev});
    chk("q", q, m_q);
    chk("ready", {35'd0, ready}, {35'd0, m_ready});
    chk("proto_err", {35'd0, proto_err}, {35'd0, m_perr});
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    r_n = 1'b1; w_n = 1'b1; d = '0; bw_n = '1;
  endtask

  // Waits for ready, checking it rises exactly LOCK cycles after cycle c0.
  task automatic wait_ready(input int c0, input string name);
    int b = 0;
    while (ready !== 1'b1 && b < LOCK + 50) begin
      @(posedge clk); #2; b++;
    end
    chk(name, DW'(cyc - c0), DW'(LOCK));
    tick();
  endtask

  // Starts at a negedge, ends at the negedge of cycle t+3.
  task automatic write_burst(input int a, input logic [DW-1:0] d0, input logic [BW-1:0] b0,
                             input logic [DW-1:0] d1, input logic [BW-1:0] b1);
    w_n = 1'b0; sa = AW'(a);
    tick(); w_n = 1'b1; d = d0; bw_n = b0;
    tick(); d = d1; bw_n = b1;
    tick(); d = '0; bw_n = '1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0, nv;
    sys_rst = 1'b0; dll_off_n = 1'b1; sa = '0;
    idle_inputs();
    tick(3);
    chk("reset_q", q, 36'h0);
    chk("reset_ready", {35'd0, ready}, 36'h0);

    // Release; commands during lock must do nothing.
    sys_rst = 1'b1; c0 = cyc;
    tick(); r_n = 1'b0; w_n = 1'b0; sa = 18'd5;
    tick(); idle_inputs();
    wait_ready(c0, "lock_time");

    // Full write then read back, RD_LAT=3.
    write_burst(5, 36'h111111111, 4'b0000, 36'h222222222, 4'b0000);
    r_n = 1'b0; sa = 18'd5;
    tick(); r_n = 1'b1;
    tick(2);
    chk("rd_beat0_valid", {35'd0, q_valid}, 36'h1);
    chk("rd_beat0", q, 36'h111111111);
    tick();
    chk("rd_beat1", q, 36'h222222222);
    tick();
    chk("rd_done_valid", {35'd0, q_valid}, 36'h0);
    chk("rd_hold", q, 36'h222222222);

    // Read and write same word same cycle; second read two cycles later.
    r_n = 1'b0; w_n = 1'b0; sa = 18'd5;
    tick(); r_n = 1'b1; w_n = 1'b1; d = 36'h333333333; bw_n = 4'b0000;
    tick(); d = 36'h444444444; r_n = 1'b0;
    tick(); idle_inputs();
    chk("collide_old0", q, 36'h111111111);
    tick();
    chk("collide_old1", q, 36'h222222222);
    tick();
    chk("after_new0", q, 36'h333333333);
    tick();
    chk("after_new1", q, 36'h444444444);
    tick();

    // Partial lane writes over zero.
    write_burst(7, 36'h0, 4'b0000, 36'h0, 4'b0000);
    write_burst(7, 36'hABCDEF1FF, 4'b1110, 36'h123456789, 4'b0111);
    r_n = 1'b0; sa = 18'd7 + 18'h00400;   // aliased upper bits
    tick(); r_n = 1'b1;
    tick(2);
    chk("partial_lane0", q, 36'h0000001FF);
    tick();
    chk("partial_lane3", q, 36'h120000000);
    tick(2);

    // Back-to-back reads at t and t+2: four contiguous beats.
    r_n = 1'b0; sa = 18'd5;
    tick(); r_n = 1'b1;
    tick(); r_n = 1'b0; sa = 18'd7;
    tick(); r_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (q_valid === 1'b1) nv++;
      tick();
    end
    chk("b2b_contig", DW'(nv), DW'(4));
    tick(2);

    // Read held low two cycles: second is a protocol error.
    chk("perr_before", {35'd0, proto_err}, 36'h0);
    r_n = 1'b0; sa = 18'd5;
    tick();
    chk("perr_not_yet", {35'd0, proto_err}, 36'h0);
    tick(); r_n = 1'b1;
    chk("perr_set", {35'd0, proto_err}, 36'h1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (q_valid === 1'b1) nv++;
      tick();
    end
    chk("perr_one_burst", DW'(nv), DW'(2));

    // DLL off mid-burst: accepted burst completes, new commands ignored.
    r_n = 1'b0; sa = 18'd7;
    tick(); r_n = 1'b1; dll_off_n = 1'b0;
    tick(); r_n = 1'b0;
    chk("dll_off_ready", {35'd0, ready}, 36'h0);
    tick(); r_n = 1'b1;
    chk("dll_off_beat0", q, 36'h0000001FF);
    tick();
    chk("dll_off_beat1", q, 36'h120000000);
    tick(4);
    dll_off_n = 1'b1; c0 = cyc;
    wait_ready(c0, "relock_time");

    // Reset one cycle after a read: no beats ever, relock needed.
    r_n = 1'b0; sa = 18'd5;
    tick(); r_n = 1'b1; sys_rst = 1'b0;
    tick(3);
    sys_rst = 1'b1; c0 = cyc;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (q_valid !== 1'b0) nv++;
      tick();
    end
    chk("rst_no_beats", DW'(nv), DW'(0));
    chk("rst_not_ready", {35'd0, ready}, 36'h0);
    chk("rst_perr_clear", {35'd0, proto_err}, 36'h0);
    wait_ready(c0, "rst_relock_time");
    tick(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
